// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between fetch_stage (master) and the memory (slave).
// The request is held until a single-cycle resp pulse returns the instruction word.
interface fetch_stage_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;

  modport master (output imem_read, imem_address, input imem_resp, imem_rdata);
  modport slave  (input imem_read, imem_address, output imem_resp, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, talks to imem, presents a registered instruction.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0060,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic                 out_valid,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instr,
  output logic [6:0]           out_opcode,
  output logic [2:0]           out_funct3,
  output logic [6:0]           out_funct7
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_bubbles
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target_q;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic [31:0] redirect_target;
  logic        out_free;
  logic        consume;

  assign redirect_target = redirect_pc & ~32'h3;
  assign out_free        = !out_valid || !stall;
  assign consume         = out_valid && !stall;

  // Gated by rst_n so the request drops the instant reset asserts and rises right after release.
  assign imem.imem_read    = rst_n && (state != HOLD);
  assign imem.imem_address = pc;

  assign out_opcode = out_instr[6:0];
  assign out_funct3 = out_instr[14:12];
  assign out_funct7 = out_instr[31:25];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      target_q   <= RESET_PC;
      hold_pc    <= '0;
      hold_instr <= NOP_INSTR;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= NOP_INSTR;
    end else if (redirect) begin
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
      unique case (state)
        FETCH: begin
          if (imem.imem_resp) begin
            pc <= redirect_target;
          end else begin
            target_q <= redirect_target;
            state    <= DROP;
          end
        end
        HOLD: begin
          pc    <= redirect_target;
          state <= FETCH;
        end
        DROP: begin
          // A response landing with a newer redirect goes straight to the newest target.
          if (imem.imem_resp) begin
            pc    <= redirect_target;
            state <= FETCH;
          end else begin
            target_q <= redirect_target;
          end
        end
        default: state <= FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (imem.imem_resp) begin
            if (out_free) begin
              out_valid <= 1'b1;
              out_instr <= imem.imem_rdata;
              out_pc    <= pc;
            end else begin
              hold_instr <= imem.imem_rdata;
              hold_pc    <= pc;
              state      <= HOLD;
            end
            pc <= pc + 32'd4;
          end else if (consume) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_valid <= 1'b1;
            out_instr <= hold_instr;
            out_pc    <= hold_pc;
            state     <= FETCH;
          end
        end
        DROP: begin
          if (imem.imem_resp) begin
            pc    <= target_q;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (consume) perf_fetched <= perf_fetched + 32'd1;
      if (!out_valid && !stall) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/latency traffic,
// checked by a transaction-level model with an expected-instruction queue.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0060;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_req = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int vectors = 0;
  int miscompares = 0;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_opcode  (out_opcode),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  // Memory image: addi x1,x1,imm below 0x100, scrambled words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h100) return {a[11:0], 5'd1, 3'b000, 5'd1, 7'h13};
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Responder state: latency chosen when a request first appears.
  bit req_open = 1'b0;
  int lat = 0;
  int lat_min = 0;
  int lat_max = 0;

  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst_n = rst_req;
    #1;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    if (!rst_n) begin
      req_open       = 1'b0;
      imem.imem_resp = 1'b0;
    end else if (imem.imem_read) begin
      if (!req_open) begin
        req_open = 1'b1;
        lat      = int'($urandom_range(lat_max, lat_min));
      end
      if (lat == 0) begin
        imem.imem_resp  = 1'b1;
        imem.imem_rdata = mem_word(imem.imem_address);
        req_open        = 1'b0;
      end else begin
        imem.imem_resp  = 1'b0;
        imem.imem_rdata = $urandom;
        lat--;
      end
    end else begin
      imem.imem_resp = 1'b0;
    end
  endtask

  // Reference model: expected fetch address plus queue of instructions owed downstream.
  item_t       exp_q[$];
  item_t       front;
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] stale_target = '0;
  logic [31:0] tgt;
  bit          stale = 1'b0;
  bit          prev_redir = 1'b0;
  bit          model_valid;
  bit          perf_chk = 1'b0;
  int          n_consumed = 0;
  int          n_bubbles = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_addr   = RESET_PC;
      stale      = 1'b0;
      prev_redir = 1'b0;
      n_consumed = 0;
      n_bubbles  = 0;
    end else begin
      model_valid = (exp_q.size() != 0);
      check("out_valid", 32'(out_valid), 32'(model_valid));
      if (model_valid) begin
        front = exp_q[0];
        check("out_pc", out_pc, front.pc);
        check("out_instr", out_instr, front.instr);
        check("out_opcode", 32'(out_opcode), 32'(front.instr[6:0]));
        check("out_funct3", 32'(out_funct3), 32'(front.instr[14:12]));
        check("out_funct7", 32'(out_funct7), 32'(front.instr[31:25]));
      end else begin
        check("bubble_instr", out_instr, NOP);
      end
      check("imem_address", imem.imem_address, exp_addr);
      check("imem_read", 32'(imem.imem_read), 32'(exp_q.size() < 2));
      if (prev_redir) check("redirect_flush", 32'(out_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      if (perf_chk) begin
        check("perf_fetched", perf_fetched, 32'(n_consumed));
        check("perf_bubbles", perf_bubbles, 32'(n_bubbles));
        perf_chk = 1'b0;
      end
`endif
      if (!stall) begin
        if (model_valid) begin
          void'(exp_q.pop_front());
          n_consumed++;
        end else begin
          n_bubbles++;
        end
      end
      tgt = redirect_pc & ~32'h3;
      if (imem.imem_read && imem.imem_resp) begin
        if (redirect) exp_addr = tgt;
        else if (stale) exp_addr = stale_target;
        else begin
          exp_q.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
          exp_addr = exp_addr + 32'd4;
        end
        stale = 1'b0;
      end else if (redirect) begin
        if (imem.imem_read) begin
          stale        = 1'b1;
          stale_target = tgt;
        end else begin
          exp_addr = tgt;
        end
      end
      if (redirect) exp_q.delete();
      prev_redir = redirect;
    end
  end

  task automatic do_reset();
    rst_req = 1'b0;
    lat_min = 0;
    lat_max = 0;
    repeat (2) tick(0, 0, '0);
  endtask

  initial begin
    imem.imem_resp  = 1'b0;
    imem.imem_rdata = '0;

    // Reset values.
    do_reset();
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, NOP);
    check("rst_read", 32'(imem.imem_read), 32'd0);

    // Back-to-back fetch, then a 4-cycle stall catching the 0x68 response.
    rst_req = 1'b1;
    tick(0, 0, '0); #1;
    check("first_addr", imem.imem_address, 32'h60);
    check("first_read", 32'(imem.imem_read), 32'd1);
    tick(0, 0, '0); #1;
    check("seq_pc0", out_pc, 32'h60);
    check("seq_opcode", 32'(out_opcode), 32'h13);
    tick(1, 0, '0); #1;
    check("seq_pc1", out_pc, 32'h64);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, '0); #1;
      check("stall_pc", out_pc, 32'h64);
      check("stall_read", 32'(imem.imem_read), 32'd0);
    end
    tick(0, 0, '0); #1;
    check("unstall_hold_pc", out_pc, 32'h64);
    tick(0, 0, '0); #1;
    check("held_pc", out_pc, 32'h68);
    check("resume_addr", imem.imem_address, 32'h6C);
    tick(0, 0, '0); #1;
    check("resume_pc", out_pc, 32'h6C);

    // Redirect to 0x200 while the 0x64 request waits three cycles.
    do_reset();
    rst_req = 1'b1;
    tick(0, 0, '0);
    lat_min = 3;
    lat_max = 3;
    tick(0, 1, 32'h200); #1;
    lat_min = 0;
    lat_max = 0;
    check("drop_addr0", imem.imem_address, 32'h64);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, '0); #1;
      check("drop_addr", imem.imem_address, 32'h64);
      check("drop_valid", 32'(out_valid), 32'd0);
    end
    tick(0, 0, '0); #1;
    check("drop_target", imem.imem_address, 32'h200);
    check("drop_read", 32'(imem.imem_read), 32'd1);
    check("drop_valid_end", 32'(out_valid), 32'd0);

    // Redirect to 0x103 coinciding with a response, under stall.
    do_reset();
    rst_req = 1'b1;
    tick(0, 0, '0);
    tick(1, 1, 32'h103);
    tick(1, 0, '0); #1;
    check("same_cycle_valid", 32'(out_valid), 32'd0);
    check("same_cycle_addr", imem.imem_address, 32'h100);
    tick(0, 0, '0); #1;
    check("same_cycle_out", out_pc, 32'h100);

    // Asynchronous reset in the middle of a request.
    @(posedge clk); #1;
    check("pre_rst_read", 32'(imem.imem_read), 32'd1);
    rst_req = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_instr", out_instr, NOP);
    check("async_read", 32'(imem.imem_read), 32'd0);
    tick(0, 0, '0);
    rst_req = 1'b1;
    tick(0, 0, '0); #1;
    check("refetch_addr", imem.imem_address, 32'h60);
    tick(0, 0, '0); #1;
    check("refetch_pc", out_pc, 32'h60);

    // PC wrap from 0xFFFFFFFC.
    tick(0, 1, 32'hFFFF_FFFC);
    tick(0, 0, '0); #1;
    check("wrap_addr0", imem.imem_address, 32'hFFFF_FFFC);
    tick(0, 0, '0); #1;
    check("wrap_addr1", imem.imem_address, 32'h0);
    check("wrap_pc", out_pc, 32'hFFFF_FFFC);

    // Random traffic.
    lat_min = 0;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, rpc);
    end
    tick(0, 0, '0);
    perf_chk = 1'b1;
    repeat (2) tick(0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core; sits directly upstream of the decode/control stage.
- Owns the PC and issues read requests to the instruction memory port, waiting for a one-cycle resp handshake.
- Presents a registered instruction and PC, plus the opcode/funct3/funct7 fields, to the control-word generator.
- Honours back-pressure (stall) from the hazard unit and branch/jump redirects from EX.

Parameters:
RESET_PC, 32'h00000060, PC value loaded on reset.
NOP_INSTR, 32'h00000013, instruction presented when out_valid=0 (addi x0,x0,0).

Ports:
clk  input  1  clock.
rst_n  input  1  reset; asynchronous, active-low.
imem_read  output  1  instruction read request.
imem_address  output  32  word-aligned fetch address.
imem_resp  input  1  read data valid, one-cycle pulse.
imem_rdata  input  32  instruction word.
stall  input  1  downstream cannot accept; hold outputs.
redirect  input  1  taken branch/jump; flush and refetch.
redirect_pc  input  32  new fetch target.
out_valid  output  1  out_instr/out_pc hold a live instruction.
out_pc  output  32  PC of out_instr.
out_instr  output  32  fetched instruction.
out_opcode  output  7  out_instr[6:0].
out_funct3  output  3  out_instr[14:12].
out_funct7  output  7  out_instr[31:25].

Behaviour:
- Reset, asynchronous: pc=RESET_PC, state=FETCH, out_valid=0, out_pc=0, out_instr=NOP_INSTR, hold buffer empty.
  - imem_read=0 while rst_n=0.
  - First request is issued in the first cycle after rst_n rises.
- imem_address=pc at all times. pc[1:0] is always 00; redirect_pc[1:0] are ignored. pc+4 wraps modulo 2^32.
- Memory rule: once imem_read is high, imem_address and imem_read stay stable until imem_resp. An outstanding request is never cancelled.
- Consume rule: downstream takes the output in any cycle with out_valid=1 and stall=0.
- States:
  - FETCH: imem_read=1.
    - imem_resp with output free (out_valid=0 or stall=0): next cycle out_instr=imem_rdata, out_pc=pc, out_valid=1; pc+=4; stay in FETCH. Latency is resp cycle N to out_valid in N+1.
    - imem_resp with output busy (out_valid=1 and stall=1): rdata and pc go to the hold buffer; pc+=4; go to HOLD.
    - No resp, output consumed: out_valid=0 next cycle.
  - HOLD: imem_read=0.
    - When stall=0: output takes the buffer contents (out_valid=1); go to FETCH.
    - While stall=1: output and buffer unchanged.
  - DROP: imem_read=1 at the old address. target_q holds the redirect address.
    - On imem_resp: discard data; pc=target_q; go to FETCH.
    - No output update in this state; out_valid=0.
- Redirect has priority over every other event, including stall.
  - Next cycle out_valid=0 and the hold buffer is cleared.
  - FETCH with no resp this cycle: target_q=redirect_pc; go to DROP.
  - FETCH with imem_resp in the same cycle: discard data; pc=redirect_pc; stay in FETCH. A new request goes out the next cycle.
  - HOLD: pc=redirect_pc; go to FETCH.
  - DROP: target_q is overwritten by the newest redirect_pc.
- When out_valid=0, out_instr=NOP_INSTR, so control decodes a harmless op_imm add. out_pc keeps its last value.
- out_opcode/out_funct3/out_funct7 are purely combinational slices of out_instr.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32) and perf_bubbles (32), both reset to 0.
  - perf_fetched increments on each consumed instruction.
  - perf_bubbles increments each cycle with out_valid=0 and stall=0.
  - Both wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, memory responds 1 cycle after each request:
  - First imem_address=32'h60.
  - out_pc sequence 60,64,68 on consecutive out_valid cycles.
  - out_instr matches memory; out_opcode=7'h13 for an addi.
- stall=1 for 4 cycles while out_valid=1 and the next resp arrives:
  - Output holds; state goes to HOLD; imem_read=0.
  - After stall drops, buffered pc 68 appears the next cycle, then fetch resumes at 6C.
- redirect to 32'h200 while a request to 64 is outstanding, resp 3 cycles later:
  - imem_address stays 64 until resp; that data is never output.
  - Next request is to 200; out_valid=0 throughout.
- redirect to 32'h103 in the same cycle as imem_resp:
  - Response dropped; next imem_address=32'h100.
  - out_valid=0 next cycle, even with stall=1.
- rst_n asserted mid-request:
  - out_valid=0, out_instr=32'h13, imem_read=0 immediately, without a clock edge.
  - After release, refetch from 60.
- pc=32'hFFFFFFFC fetched: next imem_address=32'h00000000. With FETCH_PERF_CNT_EN, perf counters match the observed consume and bubble counts.
